// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter: shares a FIFO core's write port between NUM_REQ producers
// (round-robin) and drains its read port into a valid/ready output stream.
module fifo_port_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned GW       = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ack,
  input  logic                     i_full,
  input  logic                     i_empty,
  output logic                     o_wr_en,
  output logic [WIDTH-1:0]         o_fifo_input_data,
  output logic                     o_rd_en,
  input  logic [WIDTH-1:0]         i_fifo_output_data,
  output logic                     o_out_valid,
  output logic [WIDTH-1:0]         o_out_data,
  input  logic                     i_out_ready,
  output logic [GW-1:0]            o_last_grant,
  output logic [CNT_WIDTH-1:0]     o_wr_count,
  output logic [CNT_WIDTH-1:0]     o_rd_count
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_GRANT = 2'd1, W_HOLD = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_POP = 2'd1, R_HOLD = 2'd2} rstate_t;

  // write side registers and next values
  wstate_t              r_wstate, w_wstate_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic [WIDTH-1:0]     r_wdata, w_wdata_nxt;
  logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
  logic [GW-1:0]        r_grant, w_grant_nxt;
  logic [GW-1:0]        r_ptr, w_ptr_nxt;
  logic [CNT_WIDTH-1:0] r_wcnt, w_wcnt_nxt;

  // read side registers and next values
  rstate_t              r_rstate, w_rstate_nxt;
  logic                 r_rd_en, w_rd_en_nxt;
  logic                 r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0]     r_out_data, w_out_data_nxt;
  logic [CNT_WIDTH-1:0] r_rcnt, w_rcnt_nxt;

  logic [WIDTH-1:0]     w_req_word [NUM_REQ];
  logic                 w_found;
  logic [GW-1:0]        w_sel;
  logic [GW-1:0]        w_idx;
  logic                 w_out_free;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_word[g] = i_req_data[g*WIDTH +: WIDTH];
  end

  // first requesting channel at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = GW'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // write FSM next-state and registered-output values
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_en_nxt  = 1'b0;
    w_ack_nxt    = '0;
    w_wdata_nxt  = r_wdata;
    w_grant_nxt  = r_grant;
    w_ptr_nxt    = r_ptr;
    w_wcnt_nxt   = r_wcnt;
    case (r_wstate)
      W_IDLE: begin
        if (!i_full && w_found) begin
          w_wr_en_nxt      = 1'b1;
          w_wdata_nxt      = w_req_word[w_sel];
          w_ack_nxt[w_sel] = 1'b1;
          w_grant_nxt      = w_sel;
          w_ptr_nxt        = (32'(w_sel) == NUM_REQ - 1) ? '0 : w_sel + GW'(1);
          w_wstate_nxt     = W_GRANT;
        end
      end
      W_GRANT: begin
        w_wcnt_nxt   = r_wcnt + CNT_WIDTH'(1);
        w_wstate_nxt = W_HOLD;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // write FSM state and outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wstate <= W_IDLE;
      r_wr_en  <= 1'b0;
      r_wdata  <= '0;
      r_ack    <= '0;
      r_grant  <= '0;
      r_ptr    <= '0;
      r_wcnt   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wr_en  <= w_wr_en_nxt;
      r_wdata  <= w_wdata_nxt;
      r_ack    <= w_ack_nxt;
      r_grant  <= w_grant_nxt;
      r_ptr    <= w_ptr_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  assign w_out_free = !r_out_valid || i_out_ready;

  // read FSM next-state and registered-output values
  always_comb begin
    w_rstate_nxt    = r_rstate;
    w_rd_en_nxt     = 1'b0;
    w_out_valid_nxt = r_out_valid && !i_out_ready;
    w_out_data_nxt  = r_out_data;
    w_rcnt_nxt      = r_rcnt;
    case (r_rstate)
      R_IDLE: begin
        if (!i_empty && w_out_free) begin
          w_out_data_nxt  = i_fifo_output_data;
          w_out_valid_nxt = 1'b1;
          w_rd_en_nxt     = 1'b1;
          w_rstate_nxt    = R_POP;
        end
      end
      R_POP: begin
        w_rcnt_nxt   = r_rcnt + CNT_WIDTH'(1);
        w_rstate_nxt = R_HOLD;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // read FSM state and outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rstate    <= R_IDLE;
      r_rd_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_rcnt      <= '0;
    end else begin
      r_rstate    <= w_rstate_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_rcnt      <= w_rcnt_nxt;
    end
  end

  assign o_wr_en           = r_wr_en;
  assign o_fifo_input_data = r_wdata;
  assign o_req_ack         = r_ack;
  assign o_last_grant      = r_grant;
  assign o_wr_count        = r_wcnt;
  assign o_rd_en           = r_rd_en;
  assign o_out_valid       = r_out_valid;
  assign o_out_data        = r_out_data;
  assign o_rd_count        = r_rcnt;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// tb_fifo_port_arbiter: drives producers, a behavioural FIFO core and a consumer
// around fifo_port_arbiter and compares against a round-robin reference model.
module tb_fifo_port_arbiter;
  localparam int unsigned WIDTH = 8, NUM_REQ = 4, CNT_WIDTH = 16, DEPTH = 16;

  logic        clk, reset;
  logic [3:0]  req_valid, req_ack;
  logic [31:0] req_data;
  logic        full, empty, wr_en, rd_en, out_valid, out_ready;
  logic [7:0]  fifo_in, fifo_out, out_data;
  logic [1:0]  last_grant;
  logic [15:0] wr_count, rd_count;

  logic        force_full, load_en, core_full, core_empty;
  logic [7:0]  load_data, core_head;
  logic [7:0]  core_q [$];
  logic [7:0]  chan_data [4];
  int          n_checks, n_fail;

  assign full     = core_full | force_full;
  assign empty    = core_empty;
  assign fifo_out = core_head;

  fifo_port_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .CNT_WIDTH(CNT_WIDTH)) dut (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ack(req_ack), .i_full(full), .i_empty(empty), .o_wr_en(wr_en),
    .o_fifo_input_data(fifo_in), .o_rd_en(rd_en), .i_fifo_output_data(fifo_out),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
    .o_last_grant(last_grant), .o_wr_count(wr_count), .o_rd_count(rd_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // show-ahead FIFO core model; flags settle the cycle after a strobe
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_q.delete();
      core_full  <= 1'b0;
      core_empty <= 1'b1;
      core_head  <= 8'h00;
    end else begin
      if (rd_en && core_q.size() != 0) void'(core_q.pop_front());
      if (wr_en && core_q.size() < DEPTH) core_q.push_back(fifo_in);
      if (load_en) core_q.push_back(load_data);
      core_full  <= (core_q.size() >= DEPTH);
      core_empty <= (core_q.size() == 0);
      core_head  <= (core_q.size() != 0) ? core_q[0] : 8'h00;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++)
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = chan_data[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 4'h0; force_full = 1'b0; load_en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 4'hF; req_data = $urandom; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b0 || req_ack !== 4'h0) begin n_fail++; $display("FAIL reset_write: wr_en=%0b ack=%0h want 0", wr_en, req_ack); end
    n_checks++; if (rd_en !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_read: rd_en=%0b out_valid=%0b want 0", rd_en, out_valid); end
    n_checks++; if (fifo_in !== 8'h00 || out_data !== 8'h00 || last_grant !== 2'd0) begin n_fail++; $display("FAIL reset_data: fifo_in=%0h out_data=%0h last_grant=%0d want 0", fifo_in, out_data, last_grant); end
    n_checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts: wr=%0d rd=%0d want 0", wr_count, rd_count); end
    req_valid = 4'h0; out_ready = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single_channel();
    int extra;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) chan_data[i] = 8'($urandom);
    chan_data[2] = 8'hA5; drive_data(); req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b1 || fifo_in !== 8'hA5) begin n_fail++; $display("FAIL single_write: wr_en=%0b data=%0h want 1/a5", wr_en, fifo_in); end
    n_checks++; if (req_ack !== 4'b0100 || last_grant !== 2'd2) begin n_fail++; $display("FAIL single_ack: ack=%0b grant=%0d want 0100/2", req_ack, last_grant); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL single_cnt_early: wr_count=%0d want 0", wr_count); end
    req_valid = 4'h0;
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b0 || req_ack !== 4'h0 || wr_count !== 16'd1) begin n_fail++; $display("FAIL single_after: wr_en=%0b ack=%0h wr_count=%0d want 0/0/1", wr_en, req_ack, wr_count); end
    extra = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (wr_en) extra++; end
    n_checks++; if (extra != 0 || last_grant !== 2'd2) begin n_fail++; $display("FAIL single_pulse: extra wr_en=%0d grant=%0d want 0/2", extra, last_grant); end
  endtask

  task automatic test_round_robin();
    int g, last_c, exp_ch;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) chan_data[i] = 8'($urandom);
    drive_data(); req_valid = 4'hF;
    g = 0; last_c = 0;
    for (int c = 0; c < 40 && g < 6; c++) begin
      @(negedge clk);
      if (wr_en) begin
        exp_ch = g % 4;
        n_checks++; if (req_ack !== 4'(1 << exp_ch) || last_grant !== 2'(exp_ch)) begin n_fail++; $display("FAIL rr_order: grant#%0d ack=%0b grant=%0d want ch%0d", g, req_ack, last_grant, exp_ch); end
        n_checks++; if (fifo_in !== chan_data[exp_ch]) begin n_fail++; $display("FAIL rr_data: got %0h want %0h", fifo_in, chan_data[exp_ch]); end
        if (g > 0) begin
          n_checks++; if (c - last_c != 3) begin n_fail++; $display("FAIL rr_spacing: got %0d cycles want 3", c - last_c); end
        end
        last_c = c; g++;
        chan_data[exp_ch] = 8'($urandom); drive_data();
      end else begin
        n_checks++; if (req_ack !== 4'h0) begin n_fail++; $display("FAIL rr_ack_width: ack=%0b without wr_en", req_ack); end
      end
    end
    n_checks++; if (g != 6) begin n_fail++; $display("FAIL rr_timeout: got %0d grants want 6", g); end
    req_valid = 4'h0;
  endtask

  task automatic test_full_block();
    int g, waited, blocked;
    int seq [2];
    seq[0] = 1; seq[1] = 3;
    do_reset();
    out_ready = 1'b1; force_full = 1'b1;
    for (int i = 0; i < 4; i++) chan_data[i] = 8'($urandom);
    drive_data(); req_valid = 4'b1010;
    blocked = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (wr_en || req_ack != 4'h0) blocked++; end
    n_checks++; if (blocked != 0) begin n_fail++; $display("FAIL full_block: %0d cycles with write/ack want 0", blocked); end
    force_full = 1'b0;
    g = 0; waited = 0;
    for (int c = 0; c < 12 && g < 2; c++) begin
      @(negedge clk);
      waited++;
      if (wr_en) begin
        if (g == 0) begin
          n_checks++; if (waited != 1) begin n_fail++; $display("FAIL full_release_latency: got %0d want 1", waited); end
        end
        n_checks++; if (req_ack !== 4'(1 << seq[g]) || fifo_in !== chan_data[seq[g]]) begin n_fail++; $display("FAIL full_release_order: ack=%0b data=%0h want ch%0d %0h", req_ack, fifo_in, seq[g], chan_data[seq[g]]); end
        req_valid[seq[g]] = 1'b0; g++;
      end
    end
    n_checks++; if (g != 2) begin n_fail++; $display("FAIL full_timeout: got %0d grants want 2", g); end
    req_valid = 4'h0;
  endtask

  task automatic test_read_hold();
    int pulses, got, bad;
    logic [7:0] words [2];
    logic [7:0] rx [2];
    words[0] = 8'h11; words[1] = 8'h22;
    do_reset();
    out_ready = 1'b0; pulses = 0; bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (rd_en) pulses++;
      if (out_valid && out_data !== words[0]) bad++;
      load_en = (c < 2); load_data = words[c % 2];
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_fail++; $display("FAIL hold_head: valid=%0b data=%0h want 1/11", out_valid, out_data); end
    n_checks++; if (pulses != 1 || bad != 0) begin n_fail++; $display("FAIL hold_stable: rd_en pulses=%0d unstable=%0d want 1/0", pulses, bad); end
    n_checks++; if (rd_count !== 16'd1) begin n_fail++; $display("FAIL hold_rdcnt: got %0d want 1", rd_count); end
    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (out_valid && out_ready) begin rx[got] = out_data; got++; end
      @(negedge clk);
    end
    n_checks++; if (got != 2) begin n_fail++; $display("FAIL drain_timeout: got %0d words want 2", got); end
    else begin
      n_checks++; if (rx[0] !== 8'h11 || rx[1] !== 8'h22) begin n_fail++; $display("FAIL drain_order: got %0h,%0h want 11,22", rx[0], rx[1]); end
    end
    repeat (4) @(negedge clk);
    n_checks++; if (rd_count !== 16'd2 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end: rd_count=%0d valid=%0b want 2/0", rd_count, out_valid); end
  endtask

  task automatic setup_simultaneous(output logic [7:0] w, output logic [7:0] d);
    do_reset();
    out_ready = 1'b1;
    w = 8'($urandom); d = 8'($urandom);
    load_en = 1'b1; load_data = w;
    @(negedge clk);
    load_en = 1'b0;
    chan_data[0] = d; drive_data(); req_valid = 4'b0001;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [7:0] w, d;
    setup_simultaneous(w, d);
    n_checks++; if (wr_en !== 1'b1 || rd_en !== 1'b1) begin n_fail++; $display("FAIL sim_strobes: wr_en=%0b rd_en=%0b want 1/1", wr_en, rd_en); end
    n_checks++; if (fifo_in !== d || out_data !== w || out_valid !== 1'b1) begin n_fail++; $display("FAIL sim_data: in=%0h out=%0h valid=%0b want %0h/%0h/1", fifo_in, out_data, out_valid, d, w); end
    req_valid = 4'h0;
    @(negedge clk);
    n_checks++; if (wr_count !== 16'd1 || rd_count !== 16'd1) begin n_fail++; $display("FAIL sim_counts: wr=%0d rd=%0d want 1/1", wr_count, rd_count); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w, d;
    setup_simultaneous(w, d);
    n_checks++; if (wr_en !== 1'b1 || rd_en !== 1'b1) begin n_fail++; $display("FAIL mid_setup: wr_en=%0b rd_en=%0b want 1/1", wr_en, rd_en); end
    reset = 1'b1;
    #1;
    n_checks++; if ({wr_en, rd_en, req_ack, out_valid, out_data, fifo_in, last_grant, wr_count, rd_count} !== 57'd0)
      begin n_fail++; $display("FAIL mid_reset_outputs: wr=%0b rd=%0b ack=%0h v=%0b od=%0h in=%0h g=%0d wc=%0d rc=%0d want all 0", wr_en, rd_en, req_ack, out_valid, out_data, fifo_in, last_grant, wr_count, rd_count); end
    req_valid = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    chan_data[0] = 8'($urandom); chan_data[1] = 8'($urandom); drive_data(); req_valid = 4'b0011;
    @(negedge clk);
    n_checks++; if (req_ack !== 4'b0001 || last_grant !== 2'd0 || fifo_in !== chan_data[0]) begin n_fail++; $display("FAIL mid_priority: ack=%0b grant=%0d data=%0h want 0001/0/%0h", req_ack, last_grant, fifo_in, chan_data[0]); end
    n_checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin n_fail++; $display("FAIL mid_counts: wr=%0d rd=%0d want 0/0", wr_count, rd_count); end
    req_valid = 4'h0;
    @(negedge clk);
    n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL mid_count_after: wr=%0d want 1", wr_count); end
  endtask

  task automatic test_random_traffic();
    logic [7:0] exp_stream [$];
    logic [7:0] prev_data, exp_word;
    int ptr, last_w, last_r, exp_ch, exp_wcnt, exp_rcnt;
    logic prev_wr, prev_rd, prev_full, prev_hold, exp_grant;
    do_reset();
    ptr = 0; last_w = -100; last_r = -100; exp_wcnt = 0; exp_rcnt = 0;
    prev_wr = 1'b0; prev_rd = 1'b0; prev_full = full; prev_hold = 1'b0; prev_data = 8'h00;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      // write side: mask and full as sampled on the edge just passed
      if (prev_wr) exp_wcnt++;
      n_checks++; if (wr_count !== 16'(exp_wcnt)) begin n_fail++; $display("FAIL rnd_wrcnt: c=%0d got %0d want %0d", c, wr_count, exp_wcnt); end
      exp_grant = (req_valid != 4'h0) && !prev_full && (c - last_w >= 3);
      n_checks++; if (wr_en !== exp_grant) begin n_fail++; $display("FAIL rnd_wr_en: c=%0d got %0b want %0b", c, wr_en, exp_grant); end
      if (wr_en) begin
        exp_ch = rr_pick(req_valid, ptr);
        if (exp_ch < 0) exp_ch = 0;
        n_checks++; if (req_ack !== 4'(1 << exp_ch) || last_grant !== 2'(exp_ch) || fifo_in !== chan_data[exp_ch])
          begin n_fail++; $display("FAIL rnd_grant: c=%0d ack=%0b grant=%0d data=%0h want ch%0d %0h", c, req_ack, last_grant, fifo_in, exp_ch, chan_data[exp_ch]); end
        exp_stream.push_back(chan_data[exp_ch]);
        ptr = (exp_ch + 1) % 4; last_w = c;
        if (c < 600 && $urandom_range(0, 1) == 1) chan_data[exp_ch] = 8'($urandom);
        else req_valid[exp_ch] = 1'b0;
      end else begin
        n_checks++; if (req_ack !== 4'h0) begin n_fail++; $display("FAIL rnd_ack: c=%0d ack=%0b without wr_en", c, req_ack); end
      end
      // read side
      if (prev_rd) exp_rcnt++;
      n_checks++; if (rd_count !== 16'(exp_rcnt)) begin n_fail++; $display("FAIL rnd_rdcnt: c=%0d got %0d want %0d", c, rd_count, exp_rcnt); end
      if (prev_hold) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_fail++; $display("FAIL rnd_stable: c=%0d valid=%0b data=%0h want 1/%0h", c, out_valid, out_data, prev_data); end
      end
      if (rd_en) begin
        n_checks++; if (c - last_r < 3) begin n_fail++; $display("FAIL rnd_rd_spacing: got %0d want >=3", c - last_r); end
        last_r = c;
      end
      out_ready = (c >= 600) || ($urandom_range(0, 99) < 60);
      if (out_valid && out_ready) begin
        exp_word = (exp_stream.size() != 0) ? exp_stream.pop_front() : 8'hxx;
        n_checks++; if (out_data !== exp_word) begin n_fail++; $display("FAIL rnd_out_data: c=%0d got %0h want %0h", c, out_data, exp_word); end
      end
      prev_hold = out_valid && !out_ready; prev_data = out_data;
      prev_wr = wr_en; prev_rd = rd_en; prev_full = full;
      // producers: idle channels may start a new request
      if (c < 600) begin
        for (int i = 0; i < 4; i++)
          if (!req_valid[i] && $urandom_range(0, 99) < 30) begin req_valid[i] = 1'b1; chan_data[i] = 8'($urandom); end
      end else req_valid = 4'h0;
      drive_data();
    end
    n_checks++; if (exp_stream.size() != 0) begin n_fail++; $display("FAIL rnd_drain: %0d words never delivered", exp_stream.size()); end
    n_checks++; if (rd_count !== 16'(exp_wcnt)) begin n_fail++; $display("FAIL rnd_final_rdcnt: got %0d want %0d", rd_count, exp_wcnt); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; req_valid = 4'h0; req_data = 32'h0; force_full = 1'b0;
    load_en = 1'b0; load_data = 8'h00; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) chan_data[i] = 8'h00;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_full_block();
    test_read_hold();
    test_simultaneous();
    test_reset_mid();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_port_arbiter.md
# fifo_port_arbiter

Round-robin controller that shares the single write port of the FIFO core between NUM_REQ producer channels and drains its read port into a valid/ready output stream. It sits between the producers/consumer and the FIFO core, driving the core's wr_en, rd_en and write data directly. It is the multi-master alternative to the single-master CSR path. Two small FSMs sequence writes and reads so that the core's full/empty flags are always settled before the next access.

## Interface
- WIDTH, 8: data width.
- NUM_REQ, 4: producer channels, legal 2..8.
- CNT_WIDTH, 16: width of the write/read transfer counters.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-channel write request; held until acked.
- req_data  in  NUM_REQ*WIDTH  channel i data at [i*WIDTH +: WIDTH].
- req_ack  out  NUM_REQ  one-cycle pulse: channel's data written this cycle.
- full  in  1  core full flag.
- empty  in  1  core empty flag.
- wr_en  out  1  core write strobe.
- fifo_input_data  out  WIDTH  core write data.
- rd_en  out  1  core read/pop strobe.
- fifo_output_data  in  WIDTH  core head word (show-ahead, valid while !empty).
- out_valid  out  1  output stream valid.
- out_data  out  WIDTH  output stream data.
- out_ready  in  1  consumer ready.
- last_grant  out  clog2(NUM_REQ)  index of most recently granted channel.
- wr_count  out  CNT_WIDTH  total words written; wraps modulo 2^CNT_WIDTH.
- rd_count  out  CNT_WIDTH  total words popped; wraps.

## Operation
- Core contract: a word is written on a rising edge where wr_en=1. The head word is popped on a rising edge where rd_en=1. full and empty are valid the cycle after the strobe.
- Reset values: all outputs 0, both FSMs in IDLE, round-robin pointer 0 (channel 0 highest priority).
- Write FSM: states W_IDLE, W_GRANT, W_HOLD.
  - W_IDLE: if !full and any req_valid, select the first i with req_valid[i], searching from pointer upward modulo NUM_REQ. Register wr_en=1, fifo_input_data=req_data[i], req_ack[i]=1, last_grant=i. Set pointer=(i+1) mod NUM_REQ. Go to W_GRANT. Otherwise stay.
  - W_GRANT: wr_en=0, req_ack=0, wr_count+1. Go to W_HOLD.
  - W_HOLD: one settle cycle for full and for requester data update. Go to W_IDLE.
  - Only registered outputs are driven; no combinational path from req_valid to req_ack or wr_en.
  - Requesters must present the next word or drop req_valid by the cycle after req_ack.
  - If full is set, no grant occurs and requests wait indefinitely. A request dropped before ack is never written.
- Read FSM: states R_IDLE, R_POP, R_HOLD.
  - The output register is free when !out_valid, or when out_valid && out_ready in the same cycle.
  - R_IDLE: if !empty and the output register is free, register out_data=fifo_output_data, out_valid=1, rd_en=1. Go to R_POP. Otherwise, if out_valid && out_ready, clear out_valid.
  - R_POP: rd_en=0, rd_count+1. Go to R_HOLD.
  - R_HOLD: go to R_IDLE.
  - In all read states, out_valid && out_ready clears out_valid unless a new word is loaded that same cycle.
- Write and read FSMs are independent; a simultaneous write and pop in one cycle is legal.
- Reset asserted mid-transfer: everything returns to reset values immediately. A word whose strobe was already registered is considered committed by the core. Counters restart at 0.

## Timing
- Request-to-write latency: req_valid high at edge N, with the FSM in W_IDLE, !full, and the channel selected, gives wr_en and req_ack high during cycle N+1.
- Peak write throughput: one word per 3 cycles. Fairness: with all channels requesting, each is granted once per NUM_REQ grants.
- Empty-to-output latency: !empty sampled at edge N gives out_valid high in cycle N+1.
- Peak read throughput: one word per 3 cycles. out_data is stable while out_valid && !out_ready.
- Counters update the cycle after the corresponding strobe.

## Test plan
- Reset, then channel 2 alone writes 0xA5 → single wr_en pulse with fifo_input_data=0xA5, req_ack=4'b0100, last_grant=2, wr_count=1.
- All 4 channels request continuously → grant order 0,1,2,3,0,1, each req_ack exactly one cycle, consecutive wr_en pulses 3 cycles apart.
- full=1 while channels 1 and 3 request → no wr_en and no ack. Drop full → channel 1 is granted first, then channel 3.
- Core holds words 0x11,0x22 with out_ready=0 → out_valid=1, out_data=0x11 stable, one rd_en only. Raise out_ready → 0x11 then 0x22 delivered, rd_count=2, then out_valid=0 with empty=1.
- Simultaneous write grant and read pop in the same cycle → wr_en and rd_en both high in that cycle, both counters increment.
- Reset asserted during W_GRANT/R_POP → all outputs 0 immediately. After release, channel 0 has priority and counters are 0.
